// File: rtl/ice_risc_uart_pkg.sv
// ice_risc_uart_pkg: register offsets, STATUS bit positions and TX FSM states shared by mmio_uart_tx
package ice_risc_uart_pkg;
  localparam logic [1:0] UART_OFF_TXDATA = 2'd0;
  localparam logic [1:0] UART_OFF_STATUS = 2'd1;
  localparam logic [1:0] UART_OFF_DIV    = 2'd2;
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO for the UART transmitter.
// clk_i/rst_i clock and async active-high reset; push_i/data_i write side (ignored when full);
// pop_i/data_o read side (data_o shows the head); full_o, empty_o, count_o report occupancy.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  // Fullness is judged on the pre-edge count, so a push into a full FIFO is dropped even when a pop happens on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign data_o = mem_q[rd_q];
  assign count_o = count_q;
  assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      count_q <= count_d;
    end
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO.
// iwClk/iwRst clock and async active-high reset; iwWriteAddr/iwWriteData/iwWstrb CPU store port;
// iwReadAddr/owReadData registered CPU data-read port (0 outside the window); owUartTx serial line, idle high.
module mmio_uart_tx
  import ice_risc_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter logic [15:0] DIV_RESET  = 16'd207,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        iwClk,
  input  logic        iwRst,
  input  logic [31:0] iwWriteAddr,
  input  logic [31:0] iwWriteData,
  input  logic [3:0]  iwWstrb,
  input  logic [31:0] iwReadAddr,
  output logic [31:0] owReadData,
  output logic        owUartTx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic wr_hit, rd_hit, push, pop, fifo_full, fifo_empty, ovf_q, ovf_d, tx_q, tx_d, bit_end;
  logic [1:0] wr_off, rd_off;
  logic [7:0] fifo_data, shift_q, shift_d, status;
  logic [AW:0] fifo_count;
  logic [15:0] div_q, div_d, bit_div_q, bit_div_d, cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [31:0] rdata_q, rdata_d;
  logic unused_bits;
  uart_tx_state_t state_q, state_d;
  assign unused_bits = ^{iwWriteData[31:16], iwWriteAddr[1:0], iwReadAddr[1:0]};
  assign wr_hit = |iwWstrb && iwWriteAddr[31:4] == BASE_ADDR[31:4];
  assign rd_hit = iwReadAddr[31:4] == BASE_ADDR[31:4];
  assign wr_off = iwWriteAddr[3:2];
  assign rd_off = iwReadAddr[3:2];
  assign push = wr_hit && wr_off == UART_OFF_TXDATA && iwWstrb[0];
  assign ovf_d = (push && fifo_full) ||
                 (ovf_q && !(wr_hit && wr_off == UART_OFF_STATUS && iwWstrb[0] && iwWriteData[3]));
  assign div_d = wr_hit && wr_off == UART_OFF_DIV ?
                 {iwWstrb[1] ? iwWriteData[15:8] : div_q[15:8], iwWstrb[0] ? iwWriteData[7:0] : div_q[7:0]} : div_q;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (iwClk),
    .rst_i   (iwRst),
    .push_i  (push),
    .data_i  (iwWriteData[7:0]),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );
  always_comb begin
    status = '0;
    status[STAT_FULL] = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_BUSY] = state_q != ST_IDLE;
    status[STAT_OVF] = ovf_q;
    status[STAT_COUNT_LSB +: 4] = 4'(fifo_count);
  end
  assign rdata_d = !rd_hit ? '0 :
                   rd_off == UART_OFF_STATUS ? {24'b0, status} :
                   rd_off == UART_OFF_DIV ? {16'b0, div_q} : '0;
  // Bit timing uses the divisor latched at frame start, so DIVISOR writes only affect the next frame.
  assign bit_end = cnt_q == bit_div_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 16'd1;
    bit_div_d = bit_div_q;
    idx_d = idx_q;
    shift_d = shift_q;
    tx_d = tx_q;
    pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        pop = !fifo_empty;
      end
      ST_START:
        if (bit_end) begin
          state_d = ST_DATA;
          cnt_d = '0;
          idx_d = '0;
          tx_d = shift_q[0];
          shift_d = shift_q >> 1;
        end
      ST_DATA:
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      ST_STOP:
        if (bit_end) begin
          cnt_d = '0;
          pop = !fifo_empty;
          if (fifo_empty) state_d = ST_IDLE;
        end
      default: state_d = ST_IDLE;
    endcase
    // A pop always begins a frame: from IDLE, or straight out of STOP for gap-free back-to-back frames.
    if (pop) begin
      state_d = ST_START;
      shift_d = fifo_data;
      bit_div_d = div_q;
      cnt_d = '0;
      tx_d = 1'b0;
    end
  end
  always_ff @(posedge iwClk or posedge iwRst)
    if (iwRst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      bit_div_q <= DIV_RESET;
      idx_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      div_q <= DIV_RESET;
      ovf_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_div_q <= bit_div_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      div_q <= div_d;
      ovf_q <= ovf_d;
      rdata_q <= rdata_d;
    end
  assign owReadData = rdata_q;
  assign owUartTx = tx_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench for mmio_uart_tx; serial frames and register reads are checked by monitors
module tb_mmio_uart_tx;
  localparam logic [31:0] A_TX  = 32'h1000_0000;
  localparam logic [31:0] A_ST  = 32'h1000_0004;
  localparam logic [31:0] A_DIV = 32'h1000_0008;
  localparam logic [31:0] A_RSV = 32'h1000_000C;
  typedef struct {
    logic [7:0] d;
    int         bt;
    bit         contig;
    bit         cut;
  } frame_t;
  logic iwClk = 1'b0;
  logic iwRst = 1'b1;
  logic [31:0] iwWriteAddr = '0, iwWriteData = '0, iwReadAddr = '0;
  logic [3:0] iwWstrb = '0;
  logic [31:0] owReadData;
  logic owUartTx;
  logic rd_req = 1'b0, rd_pend = 1'b0;
  logic [31:0] rq[$];
  string rn[$];
  frame_t fq[$];
  int checks = 0, errors = 0, frames_done = 0, exp_frames = 0;

  mmio_uart_tx dut (
    .iwClk       (iwClk),
    .iwRst       (iwRst),
    .iwWriteAddr (iwWriteAddr),
    .iwWriteData (iwWriteData),
    .iwWstrb     (iwWstrb),
    .iwReadAddr  (iwReadAddr),
    .owReadData  (owReadData),
    .owUartTx    (owUartTx)
  );

  always #5 iwClk = ~iwClk;
  always @(posedge iwClk) rd_pend <= rd_req;

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    iwWriteAddr = a;
    iwWriteData = d;
    iwWstrb = s;
    @(negedge iwClk);
    iwWstrb = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    iwReadAddr = a;
    rd_req = 1'b1;
    rq.push_back(e);
    rn.push_back(n);
    @(negedge iwClk);
    rd_req = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] d, input int bt, input bit contig, input bit cut);
    fq.push_back('{d, bt, contig, cut});
    exp_frames++;
  endtask

  task automatic chk(input string n, input logic g, input logic e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b", n, g, e);
    end
  endtask

  task automatic wait_frames();
    for (int i = 0; i < 4000 && frames_done < exp_frames; i++) @(negedge iwClk);
    checks++;
    if (frames_done != exp_frames) begin
      errors++;
      $display("FAIL frames_timeout: %0d frames seen, required %0d", frames_done, exp_frames);
    end
    repeat (2) @(negedge iwClk);
  endtask

  initial begin : mon_rd
    logic [31:0] e;
    string n;
    forever begin
      @(negedge iwClk);
      if (rd_pend) begin
        e = rq.pop_front();
        n = rn.pop_front();
        checks++;
        if (owReadData !== e) begin
          errors++;
          $display("FAIL read_%s: got %h, required %h", n, owReadData, e);
        end
      end
    end
  end

  initial begin : mon_tx
    int idle, bad, b;
    logic ab, eb;
    logic [7:0] got;
    frame_t e;
    idle = 1000;
    forever begin
      @(negedge iwClk);
      if (iwRst || owUartTx) begin
        idle++;
        continue;
      end
      if (fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: line went low with no frame queued, required idle high");
        for (int i = 0; i < 5000 && !owUartTx; i++) @(negedge iwClk);
        idle = 0;
        continue;
      end
      e = fq.pop_front();
      if (e.contig) begin
        checks++;
        if (idle != 0) begin
          errors++;
          $display("FAIL frame_gap: byte %h started after %0d idle cycles, required 0", e.d, idle);
        end
      end
      ab = 1'b0;
      bad = 0;
      got = '0;
      for (int k = 0; k < 10 * e.bt && !ab; k++) begin
        if (k > 0) @(negedge iwClk);
        if (iwRst) ab = 1'b1;
        else begin
          b = k / e.bt;
          eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.d[b-1];
          if (k % e.bt == 0 && b >= 1 && b <= 8) got[b-1] = owUartTx;
          if (owUartTx !== eb) bad++;
        end
      end
      checks++;
      if (ab != e.cut) begin
        errors++;
        $display("FAIL frame_abort: byte %h aborted=%0b, required %0b", e.d, ab, e.cut);
      end else if (!ab && bad != 0) begin
        errors++;
        $display("FAIL frame: got byte %h with %0d off cycles, required %h over 10x%0d cycles", got, bad, e.d, e.bt);
      end
      idle = 0;
      frames_done++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge iwClk);
    iwRst = 1'b0;
    chk("tx_idle_after_reset", owUartTx, 1'b1);
    rd(A_ST, 32'h0000_0002, "status_reset");
    rd(A_DIV, 32'd207, "div_reset");
    rd(A_TX, 32'h0, "txdata_reads_zero");
    rd(A_RSV, 32'h0, "reserved_reads_zero");
    rd(32'h2000_0004, 32'h0, "outside_window");
    rd(32'h1000_0006, 32'h0000_0002, "low_bits_ignored");

    wr(A_DIV, 32'd3, 4'b0011);
    rd(A_DIV, 32'd3, "div_3");
    expect_frame(8'h55, 4, 1'b0, 1'b0);
    wr(A_TX, 32'h55, 4'b0001);
    chk("tx_high_before_pop", owUartTx, 1'b1);
    rd(A_ST, 32'h0000_0010, "status_after_push");
    chk("tx_low_after_pop", owUartTx, 1'b0);
    rd(A_ST, 32'h0000_0006, "status_busy");
    wait_frames();
    rd(A_ST, 32'h0000_0002, "status_idle_after_55");

    wr(A_DIV, 32'd1, 4'b0011);
    for (int i = 0; i < 9; i++) expect_frame(8'(i), 2, i != 0, 1'b0);
    for (int i = 0; i < 9; i++) wr(A_TX, 32'(i), 4'b0001);
    for (int i = 0; i < 9; i++) wr(A_TX, 32'(8'h10 + i), 4'b0001);
    rd(A_ST, 32'h0000_008D, "status_full_overflow");
    wr(A_ST, 32'h0000_0008, 4'b0001);
    rd(A_ST, 32'h0000_0085, "status_overflow_cleared");
    wait_frames();
    rd(A_ST, 32'h0000_0002, "status_idle_after_burst");

    wr(A_TX, 32'h0000_0077, 4'b0010);
    rd(A_ST, 32'h0000_0002, "status_lane1_no_push");
    wr(A_DIV, 32'hABCD_1234, 4'b0011);
    rd(A_DIV, 32'h0000_1234, "div_1234");
    wr(A_DIV, 32'h0000_5600, 4'b0010);
    rd(A_DIV, 32'h0000_5634, "div_upper_lane");
    wr(A_RSV, 32'hFFFF_FFFF, 4'b1111);
    rd(A_RSV, 32'h0, "reserved_after_write");
    rd(A_DIV, 32'h0000_5634, "div_unchanged");

    wr(A_DIV, 32'd3, 4'b0011);
    expect_frame(8'hA5, 4, 1'b0, 1'b0);
    expect_frame(8'h3C, 8, 1'b1, 1'b0);
    wr(A_TX, 32'hA5, 4'b0001);
    wr(A_TX, 32'h3C, 4'b0001);
    repeat (16) @(negedge iwClk);
    wr(A_DIV, 32'd7, 4'b0011);
    wait_frames();

    wr(A_DIV, 32'd3, 4'b0011);
    expect_frame(8'h0F, 4, 1'b0, 1'b0);
    expect_frame(8'h00, 4, 1'b1, 1'b1);
    wr(A_TX, 32'h0F, 4'b0001);
    wr(A_TX, 32'h00, 4'b0001);
    wr(A_TX, 32'hF0, 4'b0001);
    repeat (46) @(negedge iwClk);
    chk("tx_low_in_frame2", owUartTx, 1'b0);
    iwRst = 1'b1;
    #1;
    chk("tx_high_on_reset", owUartTx, 1'b1);
    repeat (3) @(negedge iwClk);
    iwRst = 1'b0;
    rd(A_ST, 32'h0000_0002, "status_after_midrun_reset");
    rd(A_DIV, 32'd207, "div_after_midrun_reset");
    repeat (300) @(negedge iwClk);
    chk("tx_idle_after_release", owUartTx, 1'b1);
    checks++;
    if (frames_done != exp_frames || fq.size() != 0) begin
      errors++;
      $display("FAIL frame_count: got %0d frames with %0d pending, required %0d with 0 pending",
               frames_done, fq.size(), exp_frames);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
